reg_wb_arbiter: RTL

Write-back arbiter for the 32x32 register file's single write port. Two producers compete for that port: the ALU result path (requester 0) and the memory-load path (requester 1). The block grants one producer per cycle with round-robin fairness and drives registered RegWrite/WriteReg/WriteData. It also counts contention cycles for performance monitoring.

---
 rtl/reg_wb_arbiter.sv | 77 +++++++
 1 files changed

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - round-robin write-back arbiter for the register file write port
// Optional WB_FORWARD_EN adds a write-to-decode bypass on the registered write outputs.
module reg_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wb_stall,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic [CNT_W-1:0]  conflict_cnt
`ifdef WB_FORWARD_EN
    ,
    input  logic [ADDR_W-1:0] fwd_raddr1,
    input  logic [ADDR_W-1:0] fwd_raddr2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2
`endif
);

    logic rr_ptr;
    logic contended;
    logic grant0;
    logic grant1;

    assign contended  = req0_valid && req1_valid && !wb_stall;
    assign grant0     = !wb_stall && req0_valid && (!req1_valid || !rr_ptr);
    assign grant1     = !wb_stall && req1_valid && (!req0_valid || rr_ptr);
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite     <= 1'b0;
            WriteReg     <= '0;
            WriteData    <= '0;
            conflict_cnt <= '0;
            rr_ptr       <= 1'b0;
        end else begin
            // Writes to register 0 are consumed but never reach the register file.
            RegWrite <= (grant0 && (req0_addr != '0)) || (grant1 && (req1_addr != '0));
            if (grant0) begin
                WriteReg  <= req0_addr;
                WriteData <= req0_data;
            end else if (grant1) begin
                WriteReg  <= req1_addr;
                WriteData <= req1_data;
            end
            if (contended) begin
                rr_ptr <= grant0;
                if (conflict_cnt != '1)
                    conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_hit1  = RegWrite && (WriteReg == fwd_raddr1) && (fwd_raddr1 != '0);
    assign fwd_hit2  = RegWrite && (WriteReg == fwd_raddr2) && (fwd_raddr2 != '0);
    assign fwd_data1 = WriteData;
    assign fwd_data2 = WriteData;
`endif

endmodule
